// File: rtl/ss_axil_rr_scheduler_pkg.sv
// Shared types for the AXI-lite round-robin scheduler.
// Optional watchdog is enabled by defining SS_SCHED_TIMEOUT_EN.
package ss_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANTED   = 2'd1,
    WAIT_RESP = 2'd2
  } sched_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ss_axil_rr_scheduler_if.sv
// Per-port AXI-lite handshake view plus mux select/direction outputs.
// master = scheduler side, slave = requester/mux side.
interface ss_axil_rr_scheduler_if #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_IDX_BITS = $clog2(NUM_PORTS)
);

  logic [NUM_PORTS-1:0]     arvalid;
  logic [NUM_PORTS-1:0]     arready;
  logic [NUM_PORTS-1:0]     awvalid;
  logic [NUM_PORTS-1:0]     awready;
  logic [NUM_PORTS-1:0]     rvalid;
  logic [NUM_PORTS-1:0]     rready;
  logic [NUM_PORTS-1:0]     bvalid;
  logic [NUM_PORTS-1:0]     bready;
  logic [PORT_IDX_BITS-1:0] group_select;
  logic                     grant_valid;
  logic                     sel_is_write;
  logic                     txn_done;
  logic                     timeout_err;

  modport master (
    input  arvalid, arready, awvalid, awready,
    input  rvalid, rready, bvalid, bready,
    output group_select, grant_valid, sel_is_write,
    output txn_done, timeout_err
  );

  modport slave (
    output arvalid, arready, awvalid, awready,
    output rvalid, rready, bvalid, bready,
    input  group_select, grant_valid, sel_is_write,
    input  txn_done, timeout_err
  );

endinterface

// File: rtl/ss_rr_arbiter.sv
// Combinational round-robin arbiter: first request after last_grant wins.
// Shared by other controllers that time-multiplex a single resource.
module ss_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int IDX_BITS = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]    req,
  input  logic [IDX_BITS-1:0] last_grant,
  output logic [IDX_BITS-1:0] grant,
  output logic                valid
);

  logic [IDX_BITS-1:0] idx;

  // Walk farthest-first so the nearest request overwrites the rest.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      idx = IDX_BITS'((int'(last_grant) + k) % WIDTH);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ss_axil_rr_scheduler.sv
// Round-robin owner of one AXI-lite slave across NUM_PORTS requesters.
// Define SS_SCHED_TIMEOUT_EN to add the hung-access watchdog.
module ss_axil_rr_scheduler
  import ss_sched_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_IDX_BITS  = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  ss_axil_rr_scheduler_if.master bus
);

  if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ss_axil_rr_scheduler: bad parameters");
  end

  sched_state_t             state, state_n;
  logic [PORT_IDX_BITS-1:0] last_grant, arb_grant, gs_n, g;
  logic [NUM_PORTS-1:0]     req;
  logic arb_valid, addr_hs, resp_hs, expired;
  logic load, drop, done_n, abort_n, gv_n, wr_n;

  assign req = bus.arvalid | bus.awvalid;
  assign g   = bus.group_select;

  ss_rr_arbiter #(
    .WIDTH    (NUM_PORTS),
    .IDX_BITS (PORT_IDX_BITS)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign addr_hs = bus.sel_is_write
                 ? (bus.awvalid[g] & bus.awready[g])
                 : (bus.arvalid[g] & bus.arready[g]);
  assign resp_hs = bus.sel_is_write
                 ? (bus.bvalid[g] & bus.bready[g])
                 : (bus.rvalid[g] & bus.rready[g]);

`ifdef SS_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;

  // Saturates so a late address handshake still trips the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (load)
      wd_cnt <= '0;
    else if (state != IDLE && wd_cnt < LIMIT)
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign expired = (state != IDLE) && (wd_cnt >= LIMIT);
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= PORT_IDX_BITS'(NUM_PORTS - 1);
      bus.group_select <= '0;
      bus.grant_valid  <= 1'b0;
      bus.sel_is_write <= 1'b0;
      bus.txn_done     <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      state            <= state_n;
      if (load)
        last_grant     <= arb_grant;
      bus.group_select <= gs_n;
      bus.grant_valid  <= gv_n;
      bus.sel_is_write <= wr_n;
      bus.txn_done     <= done_n;
      bus.timeout_err  <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    drop    = 1'b0;
    done_n  = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          state_n = GRANTED;
          load    = 1'b1;
        end
      end
      GRANTED: begin
        if (addr_hs)
          state_n = WAIT_RESP;
        else if (expired)
          abort_n = 1'b1;
      end
      WAIT_RESP: begin
        done_n  = resp_hs;
        abort_n = ~resp_hs & expired;
      end
      default: state_n = IDLE;
    endcase
    // Completion or abort: hand straight to the next requester if any.
    if (done_n | abort_n) begin
      if (arb_valid) begin
        state_n = GRANTED;
        load    = 1'b1;
      end else begin
        state_n = IDLE;
        drop    = 1'b1;
      end
    end
  end

  always_comb begin
    gs_n = bus.group_select;
    gv_n = bus.grant_valid;
    wr_n = bus.sel_is_write;
    if (load) begin
      gs_n = arb_grant;
      gv_n = 1'b1;
      wr_n = bus.awvalid[arb_grant] & ~bus.arvalid[arb_grant];
    end else if (drop) begin
      gs_n = '0;
      gv_n = 1'b0;
      wr_n = 1'b0;
    end
  end

endmodule

// File: doc/ss_axil_rr_scheduler.md
Name: ss_axil_rr_scheduler

Overview:
- Fair round-robin scheduler that shares one downstream AXI-lite slave among NUM_PORTS upstream requester groups.
- Grants one port at a time and decides read vs write for that grant.
- Holds the grant until the address handshake and the matching response handshake both complete. Back-to-back re-arbitration needs no idle cycle.
- Drives the select and direction of the external AXI-lite mux/demux. Optional watchdog aborts hung accesses.

Parameters:
- NUM_PORTS, 4, number of requester groups (≥2)
- PORT_IDX_BITS, $clog2(NUM_PORTS), width of the port index
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with SS_SCHED_TIMEOUT_EN)

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- arvalid  input  NUM_PORTS  per-port AR valid
- arready  input  NUM_PORTS  per-port AR ready (as seen through mux)
- awvalid  input  NUM_PORTS  per-port AW valid
- awready  input  NUM_PORTS  per-port AW ready
- rvalid  input  NUM_PORTS  per-port R valid
- rready  input  NUM_PORTS  per-port R ready
- bvalid  input  NUM_PORTS  per-port B valid
- bready  input  NUM_PORTS  per-port B ready
- group_select  output  PORT_IDX_BITS  granted port index to mux
- grant_valid  output  1  group_select is a live grant
- sel_is_write  output  1  1 = AW/W/B path routed, 0 = AR/R path routed
- txn_done  output  1  one-cycle pulse on response handshake completion
- timeout_err  output  1  one-cycle pulse on watchdog abort (0 without feature)

Behaviour:
- Clock/reset: clk only; reset is asynchronous, active-high.
- Reset values: group_select=0, grant_valid=0, sel_is_write=0, txn_done=0, timeout_err=0, state=IDLE. RR pointer last_grant=NUM_PORTS-1, so port 0 has first priority.
- Request: req[i] = arvalid[i] | awvalid[i].
- Arbiter: combinational search starting at last_grant+1, wrapping modulo NUM_PORTS. Yields the first asserted req index plus arb_valid.
- States: IDLE, GRANTED, WAIT_RESP. All outputs are registered.
- IDLE:
  - if arb_valid → GRANTED next cycle.
  - On entry: group_select=arb grant, last_grant=arb grant, grant_valid=1.
  - sel_is_write = awvalid[g] & ~arvalid[g]; read wins when both are valid on the same port.
- GRANTED: wait for the handshake on the chosen channel of group_select.
  - sel_is_write=0: wait arvalid&arready.
  - sel_is_write=1: wait awvalid&awready.
  - On handshake → WAIT_RESP. The other channel is ignored.
- WAIT_RESP: wait rvalid&rready (read) or bvalid&bready (write).
  - On that cycle, txn_done pulses next cycle (registered).
  - If arb_valid (computed with the pointer already at the current port) → GRANTED directly with the new grant, no IDLE bubble.
  - Else → IDLE, grant_valid=0, group_select=0.
- The completing port's own pending request is eligible again, but only after all other requesting ports (pointer rotation).
- Stable grant: group_select and sel_is_write never change in GRANTED or WAIT_RESP. A requester dropping valid in GRANTED does not release the grant.
- Latency: request in IDLE → grant_valid one cycle later. Response handshake → next grant one cycle later.
- Sole requester: re-granted on each completion.
- Reset mid-operation: immediate return to reset values. No txn_done or timeout_err is emitted.

Optional Feature:
- Macro: SS_SCHED_TIMEOUT_EN.
- With it:
  - Counter, width $clog2(TIMEOUT_CYCLES+1), clears on every entry to GRANTED and increments each cycle in GRANTED/WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES-1 with no completing handshake, the access is aborted: timeout_err pulses one cycle, no txn_done, and the next state follows the WAIT_RESP completion rule (re-arbitrate or IDLE).
  - A handshake on the limit cycle takes precedence over the timeout.
- Without it: no counter, timeout_err tied to 0, TIMEOUT_CYCLES unused.

Decomposition:
- Package ss_sched_pkg:
  - sched_state_t enum {IDLE, GRANTED, WAIT_RESP}, logic [1:0]
  - localparam default TIMEOUT_CYCLES
- Sub-module ss_rr_arbiter:
  - Combinational, parameter WIDTH.
  - Inputs requests and last_grant; outputs grant index and valid.
  - Reused by other shared-resource controllers.

Test Plan:
- Reset, then arvalid=4'b0100 → grant_valid=1, group_select=2, sel_is_write=0 next cycle; after the AR handshake and an R handshake, txn_done pulses and the block returns to IDLE.
- All four ports hold arvalid for 8 transactions → grant order 0,1,2,3,0,1,2,3, with no IDLE cycle between grants.
- Port 1 with arvalid=awvalid=1 → sel_is_write=0 (read first); after completion port 1 is re-granted with sel_is_write=1.
- Port 3 granted; port 0 requests during WAIT_RESP → group_select stays 3 until the B handshake, then becomes 0 the next cycle.
- SS_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, AR handshake with no R → timeout_err pulses 16 cycles after the grant, no txn_done, next requester granted.
- Assert reset during WAIT_RESP → outputs return to reset values immediately; after release, port 0 has priority.
